// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - stereo sample handshake bundle for the I2S capture path
//
// Purpose: carries one completed left/right sample pair from the receiver
// (master) to its downstream consumer (slave) under a valid/ready handshake.
// Signals:
//   left_data     DATA_WIDTH  last accepted left sample            (master -> slave)
//   right_data    DATA_WIDTH  last accepted right sample           (master -> slave)
//   sample_valid  1           pair on left/right_data not consumed (master -> slave)
//   sample_ready  1           consumer takes the pair this cycle   (slave -> master)
interface i2s_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output left_data,
    output right_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S master receiver for the Pmod I2S2 ADC line-in path
//
// Purpose: derives mclk/sck/lrck from the system clock, deserialises the ADC
// serial stream MSB-first into left/right words and presents each completed
// stereo pair on a valid/ready handshake, flagging dropped pairs as overrun.
// Ports:
//   clk          in   system clock (100 MHz), single domain
//   rst          in   synchronous, active-high reset
//   audio_sdout  in   serial data from the ADC
//   clr_overrun  in   single-cycle pulse clearing the sticky overrun flag
//   audio_mclk   out  master clock, clk/4
//   audio_lrck   out  word select, clk/512 (0 = left, 1 = right)
//   audio_sck    out  bit clock, clk/8 (32 bit slots per channel)
//   overrun      out  sticky: a completed pair was dropped
//   smp          if   sample pair handshake (left_data, right_data,
//                     sample_valid out; sample_ready in)
module i2s_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           audio_sdout,
  input  logic           clr_overrun,
  output logic           audio_mclk,
  output logic           audio_lrck,
  output logic           audio_sck,
  output logic           overrun,
  i2s_receiver_if.master smp
);
  localparam logic [4:0] LAST_SLOT = 5'(DATA_WIDTH);

  logic [8:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d;
  logic [DATA_WIDTH-1:0] right_sr_q, right_sr_d;
  logic [DATA_WIDTH-1:0] left_data_q, left_data_d;
  logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [4:0]            slot;
  logic                  capture;
  logic                  pair_done;

  always_comb begin
    cnt_d = cnt_q + 9'd1;

    // Slot 0 after each lrck edge is the I2S one-bit delay and never carries data.
    slot      = cnt_q[7:3];
    capture   = (cnt_q[2:0] == 3'b100) && (slot != 5'd0) && (slot <= LAST_SLOT);
    pair_done = capture && cnt_q[8] && (slot == LAST_SLOT);

    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    if (capture) begin
      if (cnt_q[8]) begin
        right_sr_d = DATA_WIDTH'({right_sr_q, audio_sdout});
      end else begin
        left_sr_d = DATA_WIDTH'({left_sr_q, audio_sdout});
      end
    end

    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q && !clr_overrun;

    // The right word is taken from right_sr_d so the final bit sampled on this
    // very edge is part of the loaded pair.
    if (pair_done) begin
      if (!valid_q || smp.sample_ready) begin
        left_data_d  = left_sr_q;
        right_data_d = right_sr_d;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && smp.sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      left_sr_q    <= '0;
      right_sr_q   <= '0;
      left_data_q  <= '0;
      right_data_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      left_sr_q    <= left_sr_d;
      right_sr_q   <= right_sr_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign audio_mclk       = cnt_q[1];
  assign audio_sck        = cnt_q[2];
  assign audio_lrck       = cnt_q[8];
  assign overrun          = overrun_q;
  assign smp.left_data    = left_data_q;
  assign smp.right_data   = right_data_q;
  assign smp.sample_valid = valid_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - self-checking bench for i2s_receiver at 16- and 24-bit widths
module tb_i2s_receiver;
  localparam int W0 = 16;
  localparam int W1 = 24;

  logic clk;
  logic rst;
  logic rdy[2];
  logic clr[2];
  logic sd[2];
  logic mclk_o[2];
  logic sck_o[2];
  logic lrck_o[2];
  logic ovr_o[2];
  logic val_o[2];
  logic [31:0] l_o[2];
  logic [31:0] r_o[2];

  int wid[2] = '{W0, W1};

  // Word-level reference state: frame position, pair register and flags.
  int          m_cnt;
  logic        m_v[2];
  logic        m_ov[2];
  logic [31:0] m_l[2];
  logic [31:0] m_r[2];
  logic [31:0] cur_l[2];
  logic [31:0] cur_r[2];
  logic [31:0] nxt_l[2];
  logic [31:0] nxt_r[2];
  bit          rnd[2];

  int total;
  int bad;

  i2s_receiver_if #(.DATA_WIDTH(W0)) if16 ();
  i2s_receiver_if #(.DATA_WIDTH(W1)) if24 ();

  assign if16.sample_ready = rdy[0];
  assign if24.sample_ready = rdy[1];
  assign val_o[0] = if16.sample_valid;
  assign val_o[1] = if24.sample_valid;
  assign l_o[0]   = 32'(if16.left_data);
  assign l_o[1]   = 32'(if24.left_data);
  assign r_o[0]   = 32'(if16.right_data);
  assign r_o[1]   = 32'(if24.right_data);

  i2s_receiver #(.DATA_WIDTH(W0)) dut16 (
    .clk         (clk),
    .rst         (rst),
    .audio_sdout (sd[0]),
    .clr_overrun (clr[0]),
    .audio_mclk  (mclk_o[0]),
    .audio_lrck  (lrck_o[0]),
    .audio_sck   (sck_o[0]),
    .overrun     (ovr_o[0]),
    .smp         (if16.master)
  );

  i2s_receiver #(.DATA_WIDTH(W1)) dut24 (
    .clk         (clk),
    .rst         (rst),
    .audio_sdout (sd[1]),
    .clr_overrun (clr[1]),
    .audio_mclk  (mclk_o[1]),
    .audio_lrck  (lrck_o[1]),
    .audio_sck   (sck_o[1]),
    .overrun     (ovr_o[1]),
    .smp         (if24.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_w(input logic [31:0] v, input int w);
    return v & ((32'd1 << w) - 32'd1);
  endfunction

  // Reference model: a pair is due at frame position 256 + 8*W + 4; it loads
  // when the output slot is free or being taken, otherwise it is dropped.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        bit ov_ev;
        ov_ev = 1'b0;
        if (rst) begin
          m_v[i]  = 1'b0;
          m_ov[i] = 1'b0;
          m_l[i]  = '0;
          m_r[i]  = '0;
        end else begin
          if (m_cnt == 256 + 8 * wid[i] + 4) begin
            if (!m_v[i] || rdy[i]) begin
              m_l[i] = cur_l[i];
              m_r[i] = cur_r[i];
              m_v[i] = 1'b1;
            end else begin
              ov_ev = 1'b1;
            end
          end else if (m_v[i] && rdy[i]) begin
            m_v[i] = 1'b0;
          end
          m_ov[i] = (m_ov[i] && !clr[i]) || ov_ev;
        end
      end
      m_cnt = rst ? 0 : (m_cnt + 1) % 512;
    end
  end

  // ADC model: new bit on each sck fall, MSB in slot 1; filler outside data slots.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_cnt % 8 == 0) begin
          int          slot;
          logic [31:0] w;
          if (m_cnt == 0) begin
            cur_l[i] = rnd[i] ? mask_w($urandom, wid[i]) : nxt_l[i];
            cur_r[i] = rnd[i] ? mask_w($urandom, wid[i]) : nxt_r[i];
          end
          slot = (m_cnt / 8) % 32;
          w    = (m_cnt >= 256) ? cur_r[i] : cur_l[i];
          if (slot >= 1 && slot <= wid[i]) begin
            sd[i] = w[wid[i] - slot];
          end else begin
            sd[i] = (i == 1) ? 1'b1 : 1'($urandom);
          end
        end
        if (rnd[i]) begin
          rdy[i] = ($urandom % 4) != 0;
          clr[i] = ($urandom % 50) == 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check_eq($sformatf("valid_w%0d", wid[i]), 32'(val_o[i]), 32'(m_v[i]));
        check_eq($sformatf("overrun_w%0d", wid[i]), 32'(ovr_o[i]), 32'(m_ov[i]));
        check_eq($sformatf("left_w%0d", wid[i]), l_o[i], m_l[i]);
        check_eq($sformatf("right_w%0d", wid[i]), r_o[i], m_r[i]);
        check_eq($sformatf("mclk_w%0d", wid[i]), 32'(mclk_o[i]), 32'((m_cnt >> 1) & 1));
        check_eq($sformatf("sck_w%0d", wid[i]), 32'(sck_o[i]), 32'((m_cnt >> 2) & 1));
        check_eq($sformatf("lrck_w%0d", wid[i]), 32'(lrck_o[i]), 32'((m_cnt >> 8) & 1));
      end
    end
  end

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != c && n < 1100);
    if (m_cnt != c) check_eq("wait_cnt_timeout", 32'(m_cnt), 32'(c));
  endtask

  task automatic next_frame(input logic [31:0] l, input logic [31:0] r);
    wait_cnt(500);
    nxt_l[0] = l;
    nxt_r[0] = r;
  endtask

  initial begin
    int          first_m, first_s, first_l;
    logic [31:0] a_l, a_r, b_l, b_r;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 1'b0; clr[i] = 1'b0; sd[i] = 1'b0; rnd[i] = 1'b0;
      m_v[i] = 1'b0; m_ov[i] = 1'b0; m_l[i] = '0; m_r[i] = '0;
      cur_l[i] = '0; cur_r[i] = '0;
    end
    nxt_l[0] = 32'hA5C3;   nxt_r[0] = 32'h1234;
    nxt_l[1] = 32'h800001; nxt_r[1] = 32'h7FFFFE;

    repeat (10) @(negedge clk);
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    rst    = 1'b0;

    // Clock phase after release: cnt equals cycles since release.
    first_m = -1; first_s = -1; first_l = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (first_m < 0 && mclk_o[0]) first_m = k;
      if (first_s < 0 && sck_o[0])  first_s = k;
      if (first_l < 0 && lrck_o[0]) first_l = k;
    end
    check_eq("mclk_first_high", 32'(first_m), 32'd2);
    check_eq("sck_first_high", 32'(first_s), 32'd4);
    check_eq("lrck_first_high", 32'(first_l), 32'd256);

    wait_cnt(388);
    check_eq("valid16_before_389", 32'(val_o[0]), 32'd0);
    wait_cnt(389);
    check_eq("valid16_at_389", 32'(val_o[0]), 32'd1);
    check_eq("left16_first", l_o[0], 32'hA5C3);
    check_eq("right16_first", r_o[0], 32'h1234);
    wait_cnt(390);
    check_eq("valid16_one_cycle", 32'(val_o[0]), 32'd0);
    check_eq("overrun16_first", 32'(ovr_o[0]), 32'd0);
    wait_cnt(452);
    check_eq("valid24_before_453", 32'(val_o[1]), 32'd0);
    wait_cnt(453);
    check_eq("valid24_at_453", 32'(val_o[1]), 32'd1);
    check_eq("left24_first", l_o[1], 32'h800001);
    check_eq("right24_first", r_o[1], 32'h7FFFFE);
    rnd[1] = 1'b1;

    // Back-pressure: three frames with ready low.
    rdy[0] = 1'b0;
    next_frame(32'h0001, 32'h0002);
    wait_cnt(389);
    check_eq("hold_valid", 32'(val_o[0]), 32'd1);
    check_eq("hold_left_f1", l_o[0], 32'h0001);
    next_frame(32'h0003, 32'h0004);
    wait_cnt(400);
    check_eq("overrun_after_f2", 32'(ovr_o[0]), 32'd1);
    check_eq("hold_left_f2", l_o[0], 32'h0001);
    check_eq("hold_right_f2", r_o[0], 32'h0002);
    next_frame(32'h0005, 32'h0006);
    wait_cnt(400);
    check_eq("hold_left_f3", l_o[0], 32'h0001);
    check_eq("hold_right_f3", r_o[0], 32'h0002);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    check_eq("overrun_cleared", 32'(ovr_o[0]), 32'd0);
    check_eq("valid_before_ready", 32'(val_o[0]), 32'd1);
    rdy[0] = 1'b1;
    @(negedge clk);
    check_eq("valid_drop_after_ready", 32'(val_o[0]), 32'd0);

    // Ready arriving exactly on the pair-complete edge with a pair pending.
    rdy[0] = 1'b0;
    a_l = mask_w($urandom, W0); a_r = mask_w($urandom, W0);
    b_l = mask_w($urandom, W0); b_r = mask_w($urandom, W0);
    next_frame(a_l, a_r);
    wait_cnt(389);
    check_eq("pend_left", l_o[0], a_l);
    next_frame(b_l, b_r);
    wait_cnt(388);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check_eq("edge_valid", 32'(val_o[0]), 32'd1);
    check_eq("edge_left", l_o[0], b_l);
    check_eq("edge_right", r_o[0], b_r);
    check_eq("edge_overrun", 32'(ovr_o[0]), 32'd0);
    rdy[0] = 1'b1;

    // Reset in the middle of the right channel.
    a_l = mask_w($urandom, W0); a_r = mask_w($urandom, W0);
    b_l = mask_w($urandom, W0); b_r = mask_w($urandom, W0);
    next_frame(a_l, a_r);
    wait_cnt(300);
    rst = 1'b1;
    nxt_l[0] = b_l;
    nxt_r[0] = b_r;
    repeat (3) @(negedge clk);
    check_eq("valid_in_reset", 32'(val_o[0]), 32'd0);
    rst = 1'b0;
    wait_cnt(388);
    check_eq("no_valid_aborted", 32'(val_o[0]), 32'd0);
    wait_cnt(389);
    check_eq("post_reset_valid", 32'(val_o[0]), 32'd1);
    check_eq("post_reset_left", l_o[0], b_l);
    check_eq("post_reset_right", r_o[0], b_r);

    // Randomized words, ready and clear pulses on both widths.
    rnd[0] = 1'b1;
    repeat (6 * 512) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
